// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for mem_port_arbiter
package mem_arb_pkg;

    // Entry fields are sized for the largest legal configuration (8 ports, 128-bit bus).
    localparam int PORT_IDX_MAX_W = 3;
    localparam int LANE_IDX_MAX_W = 2;

    typedef struct packed {
        logic [PORT_IDX_MAX_W-1:0] port;
        logic [LANE_IDX_MAX_W-1:0] lane;
    } arb_entry_t;

    // Width of a 32-bit lane index on a mem_w-bit bus, never below 1.
    function automatic int lane_w(input int mem_w);
        return (mem_w / 32 > 1) ? $clog2(mem_w / 32) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rtl/mem_port_arbiter_rr_arbiter.sv - rotating-priority request picker
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan from ptr_i upward with wrap-around; the first active request wins.
    always_comb begin
        int c;
        c       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                idx_o    = IW'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port memory arbiter with in-order response routing; option MEM_PORT_ARB_UNEXP_RSP_EN
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int MEM_W       = 32,
    parameter int MAX_OUTST   = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_PORTS-1:0]       req_i,
    output logic [NUM_PORTS-1:0]       gnt_o,
    input  logic [NUM_PORTS-1:0][31:0] addr_i,
    input  logic [NUM_PORTS-1:0]       we_i,
    input  logic [NUM_PORTS-1:0][3:0]  be_i,
    input  logic [NUM_PORTS-1:0][31:0] wdata_i,
    output logic [NUM_PORTS-1:0]       rvalid_o,
    output logic [31:0]                rdata_o,
    output logic                       err_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [MEM_W/8-1:0]         mem_be_o,
    output logic [MEM_W-1:0]           mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic [MEM_W-1:0]           mem_rdata_i,
    input  logic                       mem_err_i,
    output logic                       unexp_rsp_o
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LANES  = MEM_W / 32;
    localparam int LANE_W = lane_w(MEM_W);
    localparam int PTR_W  = $clog2(MAX_OUTST);
    localparam int CNT_W  = PTR_W + 1;

    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     arb_ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_PORTS-1:0] win_onehot;
    logic                 any_req;
    logic                 can_issue;
    logic                 accept;
    logic                 pop;
    logic [LANE_W-1:0]    win_lane;
    logic [LANE_W-1:0]    head_lane;
    logic [MEM_W/8-1:0]   be_ext;
    arb_entry_t           fifo_q [MAX_OUTST];
    arb_entry_t           head;
    arb_entry_t           push_entry;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    // Fixed priority reuses the rotating picker with its start point pinned to port 0.
    assign arb_ptr = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (arb_ptr),
        .gnt_o   (win_onehot),
        .idx_o   (win_idx),
        .valid_o (any_req)
    );

    // A response popping this cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = (count_q < CNT_W'(MAX_OUTST)) | mem_rvalid_i;
    assign mem_req_o = any_req & can_issue;
    assign accept    = mem_req_o & mem_gnt_i;
    assign gnt_o     = accept ? win_onehot : '0;

    if (LANES > 1) begin : g_lane
        assign win_lane = addr_i[win_idx][LANE_W+1:2];
    end else begin : g_no_lane
        assign win_lane = '0;
    end

    // Drive the winner onto the wide bus: data replicated, byte enables only in its lane.
    always_comb begin
        be_ext       = '0;
        be_ext[3:0]  = be_i[win_idx];
        mem_addr_o   = addr_i[win_idx];
        mem_we_o     = we_i[win_idx];
        mem_be_o     = be_ext << (4 * win_lane);
        mem_wdata_o  = {LANES{wdata_i[win_idx]}};
    end

    assign push_entry.port = PORT_IDX_MAX_W'(win_idx);
    assign push_entry.lane = LANE_IDX_MAX_W'(win_lane);
    assign head            = fifo_q[rd_ptr_q];
    assign head_lane       = head.lane[LANE_W-1:0];
    assign pop             = mem_rvalid_i & (count_q != '0);

    // Route each response to the port at the FIFO head; responses with nothing outstanding are dropped.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (pop) begin
            rvalid_o[head.port[IDX_W-1:0]] = 1'b1;
            rdata_o = mem_rdata_i[32*head_lane +: 32];
            err_o   = mem_err_i;
        end
    end

    // Pointer moves past the winner only when memory accepts, so it holds through stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Outstanding-request pointers and occupancy; pointers wrap naturally at MAX_OUTST.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: only slots below count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (accept) fifo_q[wr_ptr_q] <= push_entry;
    end

`ifdef MEM_PORT_ARB_UNEXP_RSP_EN
    logic unexp_q;

    // Flag any response arriving with nothing outstanding; held until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unexp_q <= 1'b0;
        end else if (mem_rvalid_i && (count_q == '0)) begin
            unexp_q <= 1'b1;
        end
    end

    assign unexp_rsp_o = unexp_q;

    unexp_rsp_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(mem_rvalid_i && (count_q == '0)));
`else
    assign unexp_rsp_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (round-robin and fixed-priority instances)
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0]       req;
    logic [2:0]       we;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][3:0]  be;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic             mem_err;
    logic [63:0]      mem_rdata;

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    wire [1:0][2:0]  gnt_a;
    wire [1:0][2:0]  rv_a;
    wire [1:0]       mreq_a;
    wire [1:0]       we_a;
    wire [1:0]       err_a;
    wire [1:0]       unexp_a;
    wire [1:0][31:0] rdata_a;
    wire [1:0][31:0] maddr_a;
    wire [1:0][7:0]  be_a;
    wire [1:0][63:0] wd_a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(3), .MEM_W(64), .MAX_OUTST(4), .ROUND_ROBIN(1)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_a[0]), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rv_a[0]), .rdata_o(rdata_a[0]), .err_o(err_a[0]),
        .mem_req_o(mreq_a[0]), .mem_gnt_i(mem_gnt), .mem_addr_o(maddr_a[0]), .mem_we_o(we_a[0]),
        .mem_be_o(be_a[0]), .mem_wdata_o(wd_a[0]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .mem_err_i(mem_err), .unexp_rsp_o(unexp_a[0])
    );

    mem_port_arbiter #(.NUM_PORTS(3), .MEM_W(64), .MAX_OUTST(4), .ROUND_ROBIN(0)) u_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_a[1]), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rv_a[1]), .rdata_o(rdata_a[1]), .err_o(err_a[1]),
        .mem_req_o(mreq_a[1]), .mem_gnt_i(mem_gnt), .mem_addr_o(maddr_a[1]), .mem_we_o(we_a[1]),
        .mem_be_o(be_a[1]), .mem_wdata_o(wd_a[1]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .mem_err_i(mem_err), .unexp_rsp_o(unexp_a[1])
    );

    // Reference model: a queue of {port, lane} per instance plus the next-start port.
    int          ptr_m [2];
    int          fq0 [$];
    int          fq1 [$];
    logic [2:0]  e_gnt [2];
    logic [2:0]  e_rv [2];
    logic        e_req [2];
    logic        e_err [2];
    logic        e_we [2];
    logic [31:0] e_rdata [2];
    logic [31:0] e_addr [2];
    logic [7:0]  e_be [2];
    logic [63:0] e_wd [2];
    int          e_w [2];

    function automatic int q_size(int d);
        return (d == 0) ? fq0.size() : fq1.size();
    endfunction

    function automatic int q_head(int d);
        return (d == 0) ? fq0[0] : fq1[0];
    endfunction

    task automatic model_reset();
        fq0.delete();
        fq1.delete();
        ptr_m[0] = 0;
        ptr_m[1] = 0;
    endtask

    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            int start, w, lane, cnt, hd;
            cnt   = q_size(d);
            start = (d == 0) ? ptr_m[0] : 0;
            w     = -1;
            for (int k = 0; k < 3; k++)
                if (w < 0 && req[(start + k) % 3]) w = (start + k) % 3;
            e_w[d]   = w;
            e_req[d] = (w >= 0) && (cnt < 4 || mem_rvalid);
            e_gnt[d] = (e_req[d] && mem_gnt) ? 3'(1 << w) : 3'b000;
            if (w >= 0) begin
                lane      = int'(addr[w][2]);
                e_addr[d] = addr[w];
                e_we[d]   = we[w];
                e_be[d]   = 8'(be[w]) << (4 * lane);
                e_wd[d]   = {wdata[w], wdata[w]};
            end
            if (mem_rvalid && cnt > 0) begin
                hd         = q_head(d);
                e_rv[d]    = 3'(1 << (hd / 2));
                e_rdata[d] = (hd % 2 == 1) ? mem_rdata[63:32] : mem_rdata[31:0];
                e_err[d]   = mem_err;
            end else begin
                e_rv[d]    = 3'b000;
                e_rdata[d] = 32'h0;
                e_err[d]   = 1'b0;
            end
        end
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            if (mem_rvalid && q_size(d) > 0) begin
                if (d == 0) void'(fq0.pop_front());
                else        void'(fq1.pop_front());
            end
            if (e_gnt[d] != 3'b000) begin
                if (d == 0) fq0.push_back(e_w[d] * 2 + int'(addr[e_w[d]][2]));
                else        fq1.push_back(e_w[d] * 2 + int'(addr[e_w[d]][2]));
                if (d == 0) ptr_m[0] = (e_w[d] + 1) % 3;
            end
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
    task automatic settle();
        #4;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        mem_rvalid = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (mreq_a[d] !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_req dut%0d got=%b exp=0", d, mreq_a[d]); end
            n_checks++; if (gnt_a[d] !== 3'b000)  begin n_fail++; $display("FAIL reset_gnt dut%0d got=%b exp=000", d, gnt_a[d]); end
            n_checks++; if (rv_a[d] !== 3'b000)   begin n_fail++; $display("FAIL reset_rvalid dut%0d got=%b exp=000", d, rv_a[d]); end
            n_checks++; if (unexp_a[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_unexp dut%0d got=%b exp=0", d, unexp_a[d]); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b0;
        req = 3'b111;
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (gnt_a[0] !== 3'b001) begin n_fail++; $display("FAIL reset_rr_ptr got=%b exp=001", gnt_a[0]); end
        advance();
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        addr[0] = 32'h300; addr[1] = 32'h100; addr[2] = 32'h200;
        req = 3'b110;
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (gnt_a[1] !== 3'b010) begin n_fail++; $display("FAIL fp_gnt_first got=%b exp=010", gnt_a[1]); end
        n_checks++; if (maddr_a[1] !== 32'h100) begin n_fail++; $display("FAIL fp_addr_first got=%h exp=00000100", maddr_a[1]); end
        advance();
        req = 3'b100;
        settle();
        n_checks++; if (gnt_a[1] !== 3'b100) begin n_fail++; $display("FAIL fp_gnt_second got=%b exp=100", gnt_a[1]); end
        advance();
        req = 3'b000;
        mem_rvalid = 1'b1;
        mem_rdata = 64'hA;
        settle();
        n_checks++; if (rv_a[1] !== 3'b010 || rdata_a[1] !== 32'hA) begin n_fail++; $display("FAIL fp_rsp_a got=%b/%h exp=010/0000000a", rv_a[1], rdata_a[1]); end
        advance();
        mem_rdata = 64'hB;
        settle();
        n_checks++; if (rv_a[1] !== 3'b100 || rdata_a[1] !== 32'hB) begin n_fail++; $display("FAIL fp_rsp_b got=%b/%h exp=100/0000000b", rv_a[1], rdata_a[1]); end
        advance();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        req = 3'b111;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        for (int p = 0; p < 3; p++) addr[p] = $urandom & 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) begin
            mem_rdata = {$urandom, $urandom};
            settle();
            n_checks++; if (gnt_a[0] !== exp_seq[i]) begin n_fail++; $display("FAIL rr_seq step%0d got=%b exp=%b", i, gnt_a[0], exp_seq[i]); end
            n_checks++; if (gnt_a[1] !== 3'b001) begin n_fail++; $display("FAIL fp_seq step%0d got=%b exp=001", i, gnt_a[1]); end
            n_checks++; if (rv_a[0] !== e_rv[0] || rdata_a[0] !== e_rdata[0]) begin n_fail++; $display("FAIL rr_seq_rsp step%0d got=%b/%h exp=%b/%h", i, rv_a[0], rdata_a[0], e_rv[0], e_rdata[0]); end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_full_fifo();
        do_reset();
        req = 3'b001;
        mem_gnt = 1'b1;
        addr[0] = 32'h40;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++; if (gnt_a[0] !== 3'b001) begin n_fail++; $display("FAIL full_fill issue%0d got=%b exp=001", i, gnt_a[0]); end
            advance();
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (mreq_a[d] !== 1'b0 || gnt_a[d] !== 3'b000) begin n_fail++; $display("FAIL full_block dut%0d got=%b/%b exp=0/000", d, mreq_a[d], gnt_a[d]); end
        end
        advance();
        mem_rvalid = 1'b1;
        mem_rdata = {$urandom, $urandom};
        settle();
        n_checks++; if (mreq_a[0] !== 1'b1 || gnt_a[0] !== 3'b001 || rv_a[0] !== 3'b001) begin n_fail++; $display("FAIL full_pop_issue got=%b/%b/%b exp=1/001/001", mreq_a[0], gnt_a[0], rv_a[0]); end
        advance();
        mem_rvalid = 1'b0;
        settle();
        n_checks++; if (mreq_a[0] !== 1'b0) begin n_fail++; $display("FAIL full_count_held got=%b exp=0", mreq_a[0]); end
        advance();
        req = 3'b000;
        mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++; if (rv_a[0] !== 3'b001) begin n_fail++; $display("FAIL full_drain rsp%0d got=%b exp=001", i, rv_a[0]); end
            advance();
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (rv_a[d] !== 3'b000) begin n_fail++; $display("FAIL empty_drop dut%0d got=%b exp=000", d, rv_a[d]); end
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_lanes();
        do_reset();
        req = 3'b010;
        addr[1] = 32'h104;
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (maddr_a[0] !== 32'h104 || gnt_a[0] !== 3'b010) begin n_fail++; $display("FAIL lane_rd_issue got=%h/%b exp=00000104/010", maddr_a[0], gnt_a[0]); end
        advance();
        req = 3'b000;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1111_2222_3333_4444;
        settle();
        n_checks++; if (rv_a[0] !== 3'b010 || rdata_a[0] !== 32'h1111_2222) begin n_fail++; $display("FAIL lane_rd_upper got=%b/%h exp=010/11112222", rv_a[0], rdata_a[0]); end
        advance();
        mem_rvalid = 1'b0;
        req = 3'b010;
        we = 3'b010;
        be[1] = 4'b0011;
        wdata[1] = 32'hDEAD_BEEF;
        settle();
        n_checks++; if (be_a[0] !== 8'h30) begin n_fail++; $display("FAIL lane_wr_be got=%h exp=30", be_a[0]); end
        n_checks++; if (wd_a[0] !== 64'hDEAD_BEEF_DEAD_BEEF || we_a[0] !== 1'b1) begin n_fail++; $display("FAIL lane_wr_data got=%h/%b exp=deadbeefdeadbeef/1", wd_a[0], we_a[0]); end
        advance();
        we = 3'b000;
        addr[1] = 32'h100;
        settle();
        n_checks++; if (be_a[0] !== 8'h03) begin n_fail++; $display("FAIL lane_low_be got=%h exp=03", be_a[0]); end
        advance();
        req = 3'b000;
        mem_rvalid = 1'b1;
        settle();
        advance();
        settle();
        n_checks++; if (rv_a[0] !== 3'b010 || rdata_a[0] !== 32'h3333_4444) begin n_fail++; $display("FAIL lane_rd_lower got=%b/%h exp=010/33334444", rv_a[0], rdata_a[0]); end
        advance();
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        req = 3'b011;
        addr[0] = 32'h88;
        addr[1] = 32'h99;
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (gnt_a[0] !== 3'b000 || mreq_a[0] !== 1'b1) begin n_fail++; $display("FAIL stall_gnt cyc%0d got=%b/%b exp=000/1", i, gnt_a[0], mreq_a[0]); end
            n_checks++; if (maddr_a[0] !== 32'h88) begin n_fail++; $display("FAIL stall_addr cyc%0d got=%h exp=00000088", i, maddr_a[0]); end
            advance();
        end
        mem_gnt = 1'b1;
        settle();
        n_checks++; if (gnt_a[0] !== 3'b001) begin n_fail++; $display("FAIL stall_release got=%b exp=001", gnt_a[0]); end
        advance();
        settle();
        n_checks++; if (gnt_a[0] !== 3'b010) begin n_fail++; $display("FAIL stall_ptr_next got=%b exp=010", gnt_a[0]); end
        advance();
        idle_inputs();
    endtask

    task automatic test_reset_outstanding();
        logic exp_unexp;
`ifdef MEM_PORT_ARB_UNEXP_RSP_EN
        exp_unexp = 1'b1;
`else
        exp_unexp = 1'b0;
`endif
        do_reset();
        req = 3'b011;
        mem_gnt = 1'b1;
        settle();
        advance();
        settle();
        advance();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        #1;
        mem_rvalid = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (rv_a[d] !== 3'b000) begin n_fail++; $display("FAIL rst_outst_rvalid dut%0d got=%b exp=000", d, rv_a[d]); end
        end
        advance();
        mem_rvalid = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            n_checks++; if (unexp_a[d] !== exp_unexp) begin n_fail++; $display("FAIL rst_outst_unexp dut%0d got=%b exp=%b", d, unexp_a[d], exp_unexp); end
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = 3'($urandom);
            we  = 3'($urandom);
            for (int p = 0; p < 3; p++) begin
                addr[p]  = $urandom & 32'hFFFF_FFFC;
                be[p]    = 4'($urandom);
                wdata[p] = $urandom;
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 1) == 0);
            mem_err    = 1'($urandom);
            mem_rdata  = {$urandom, $urandom};
            settle();
            for (int d = 0; d < 2; d++) begin
                n_checks++; if (mreq_a[d] !== e_req[d] || gnt_a[d] !== e_gnt[d]) begin n_fail++; $display("FAIL rand_gnt dut%0d cyc%0d got=%b/%b exp=%b/%b", d, i, mreq_a[d], gnt_a[d], e_req[d], e_gnt[d]); end
                n_checks++; if (rv_a[d] !== e_rv[d] || rdata_a[d] !== e_rdata[d] || err_a[d] !== e_err[d]) begin n_fail++; $display("FAIL rand_rsp dut%0d cyc%0d got=%b/%h/%b exp=%b/%h/%b", d, i, rv_a[d], rdata_a[d], err_a[d], e_rv[d], e_rdata[d], e_err[d]); end
                if (e_req[d]) begin
                    n_checks++; if (maddr_a[d] !== e_addr[d] || we_a[d] !== e_we[d] || be_a[d] !== e_be[d] || wd_a[d] !== e_wd[d]) begin n_fail++; $display("FAIL rand_bus dut%0d cyc%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", d, i, maddr_a[d], we_a[d], be_a[d], wd_a[d], e_addr[d], e_we[d], e_be[d], e_wd[d]); end
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_full_fifo();
        test_lanes();
        test_stall();
        test_reset_outstanding();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- N-requestor memory arbiter for the SoC (core instr, core data, vector LSU, ...) onto one shared MEM_W-bit memory port.
- Generalises the fixed 2-port instr/data arbiter:
  - parametrised port count;
  - round-robin or fixed priority;
  - downstream grant backpressure;
  - bounded in-order outstanding-request FIFO that routes responses back to the issuing port.
- Each requestor port is 32-bit, with sub-word lane placement onto the wider memory bus.

Parameters:
- NUM_PORTS, 3, number of requestor ports (2..8).
- MEM_W, 32, memory data width (32, 64 or 128).
- MAX_OUTST, 8, max in-flight requests (power of 2, 2..32).
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 highest.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- gnt_o  out  NUM_PORTS  per-port grant (one-hot or zero).
- addr_i  in  NUM_PORTS x 32  per-port byte address.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS x 4  per-port byte enables.
- wdata_i  in  NUM_PORTS x 32  per-port write data.
- rvalid_o  out  NUM_PORTS  per-port response valid (one-hot or zero).
- rdata_o  out  32  response data, shared by all ports.
- err_o  out  1  response error, shared by all ports.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepts request.
- mem_addr_o  out  32  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  MEM_W/8  memory byte enables.
- mem_wdata_o  out  MEM_W  memory write data.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  MEM_W  memory read data.
- mem_err_i  in  1  memory error.
- unexp_rsp_o  out  1  sticky unexpected-response flag (optional feature only).

Behaviour:
- Reset:
  - gnt_o, rvalid_o, mem_req_o and unexp_rsp_o are 0.
  - FIFO count = 0; round-robin pointer = 0.
  - Reset mid-operation discards all outstanding entries; later mem_rvalid_i is treated as a response arriving with the FIFO empty.
- can_issue = (count < MAX_OUTST) | mem_rvalid_i. A pop in the same cycle frees a slot, so a full FIFO plus a response still allows an issue.
- Arbitration (combinational):
  - Winner w is chosen among req_i.
  - ROUND_ROBIN=1: search starts at rr_ptr.
  - ROUND_ROBIN=0: lowest index wins.
- mem_req_o = |req_i & can_issue. Memory fields are driven from w.
- gnt_o[w] = mem_req_o & mem_gnt_i. Grant is zero-latency, in the same cycle as the request.
- rr_ptr <= (w+1) mod NUM_PORTS, only on an accepted grant. The pointer holds while memory stalls.
- Lane placement:
  - lane = addr[$clog2(MEM_W/8)-1:2].
  - mem_addr_o = addr_i[w] unchanged.
  - mem_wdata_o = wdata_i[w] replicated across all lanes.
  - mem_be_o = be_i[w] shifted to the lane; all other lanes are 0.
- FIFO entry = {port index, lane}, pushed on an accepted grant.
- On mem_rvalid_i with count > 0:
  - head is popped;
  - rvalid_o[head.port] = 1 in the same cycle (combinational, zero added latency);
  - rdata_o = mem_rdata_i[head.lane*32 +: 32];
  - err_o = mem_err_i.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo MAX_OUTST.
- mem_rvalid_i with count == 0: dropped; no rvalid_o.
- Responses are strictly in issue order; the memory is required to respond in order.
- rdata_o and err_o are don't-care when no rvalid_o is set. They are driven 0 for determinism.

Optional Feature:
- MEM_PORT_ARB_UNEXP_RSP_EN defined:
  - unexp_rsp_o sets on mem_rvalid_i while count == 0 (no same-cycle push counted).
  - Sticky until reset.
  - Simulation assertion fires on the same event.
- Undefined: unexp_rsp_o tied 0; no check logic.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_entry_t {port idx [$clog2(NUM_PORTS)-1:0], lane};
  - localparams LANES = MEM_W/32 and LANE_W = $clog2(LANES) (min 1).
- Sub-module rr_arbiter (req vector + ptr in, one-hot grant + index out), shared by both modes with the ptr forced to 0 when ROUND_ROBIN=0.
- The FIFO is inline.

Test Plan:
- Fixed priority, NUM_PORTS=3, req_i=3'b110, mem_gnt_i=1 -> gnt_o=3'b010, then on the next cycle 3'b100; mem responses 0xA, 0xB -> rvalid_o[1] with 0xA, then rvalid_o[2] with 0xB.
- Round-robin, all ports requesting continuously for 6 cycles -> grant sequence 0,1,2,0,1,2.
- Full FIFO, MAX_OUTST=4, 4 issued, no responses -> mem_req_o=0. The cycle with mem_rvalid_i=1 and req pending -> issue accepted and count stays 4.
- MEM_W=64, port 1 read at 0x104, mem_rdata_i=64'h1111_2222_3333_4444 -> rdata_o=32'h1111_2222. Write be=4'b0011 at 0x104 -> mem_be_o=8'h30.
- mem_gnt_i=0 for 3 cycles with port 0 requesting -> gnt_o=0, rr_ptr holds, mem_addr_o stable; grant on the 4th cycle.
- Reset asserted with 2 outstanding, then mem_rvalid_i -> no rvalid_o. With MEM_PORT_ARB_UNEXP_RSP_EN -> unexp_rsp_o=1.
